// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
// ============================================================================
// wb_arbiter
// ----------------------------------------------------------------------------
// Write side of the register file's single write port. Single-cycle ALU
// results always win the port; long-latency results (load/divide) arrive over
// a valid/ready handshake into a small FIFO. They drain whenever the ALU
// leaves the port idle. A busy scoreboard tracks destinations of issued
// long-latency ops, so that decode can stall on them.
//
// Optional feature, macro WB_FALLTHROUGH_EN:
//   When the FIFO is empty and the ALU is idle, an offered long-latency result
//   skips the FIFO and is written the next cycle. Without the macro, every
//   long-latency result is queued, with a minimum latency of 2 cycles.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data      ALU result; cannot be back-pressured
//   mem_valid/mem_ready            long-latency result handshake
//   mem_rd/mem_data                long-latency result payload
//   issue_valid/issue_rd           long-latency op issued (sets busy)
//   busy                           per-register write-pending bits
//   hold                           FIFO full; pipeline must insert bubbles
//   RegWrite/WriteAddr/WriteData   registered register-file write port
// ============================================================================
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int AW    = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_valid,
   input  logic [AW-1:0]        alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [AW-1:0]        mem_rd,
   input  logic [XLEN-1:0]      mem_data,
   input  logic                 issue_valid,
   input  logic [AW-1:0]        issue_rd,
   output logic [(2**AW)-1:0]   busy,
   output logic                 hold,
   output logic                 RegWrite,
   output logic [AW-1:0]        WriteAddr,
   output logic [XLEN-1:0]      WriteData
);

   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int NREG = 2**AW;

   // FIFO storage is data only; it is never reset, since validity comes from count.
   logic [AW-1:0]   fifo_rd   [DEPTH];
   logic [XLEN-1:0] fifo_data [DEPTH];
   logic [PW-1:0]   wptr, rptr;
   logic [CW-1:0]   count;

   logic full, empty, push, pop, bypass;

   // Next-cycle write port and scoreboard values (stage p0, registered into the port)
   logic            wr_en_p0;
   logic [AW-1:0]   wr_addr_p0;
   logic [XLEN-1:0] wr_data_p0;
   logic            clr_en_p0;
   logic [AW-1:0]   clr_rd_p0;
   logic [NREG-1:0] set_mask_p0, clr_mask_p0, busy_p0;

   // Full/ready decode from the registered count only, so there is no
   // combinational path from mem_valid or alu_valid to mem_ready.
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign mem_ready = !full;
   assign hold      = full;

   assign pop = !alu_valid && !empty;

`ifdef WB_FALLTHROUGH_EN
   assign bypass = !alu_valid && empty && mem_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed result is consumed directly and never occupies a slot.
   assign push = mem_valid && !full && !bypass;

   always_comb begin
      wr_en_p0   = 1'b0;
      wr_addr_p0 = WriteAddr;
      wr_data_p0 = WriteData;
      clr_en_p0  = 1'b0;
      clr_rd_p0  = '0;
      if (alu_valid) begin
         wr_en_p0   = (alu_rd != '0);
         wr_addr_p0 = alu_rd;
         wr_data_p0 = alu_data;
      end else if (pop) begin
         wr_en_p0   = (fifo_rd[rptr] != '0);
         wr_addr_p0 = fifo_rd[rptr];
         wr_data_p0 = fifo_data[rptr];
         clr_en_p0  = (fifo_rd[rptr] != '0);
         clr_rd_p0  = fifo_rd[rptr];
      end else if (bypass) begin
         wr_en_p0   = (mem_rd != '0);
         wr_addr_p0 = mem_rd;
         wr_data_p0 = mem_data;
         clr_en_p0  = (mem_rd != '0);
         clr_rd_p0  = mem_rd;
      end
   end

   // Set is OR-ed in after the clear, so a same-register issue wins.
   always_comb begin
      set_mask_p0 = '0;
      clr_mask_p0 = '0;
      if (issue_valid && (issue_rd != '0)) set_mask_p0[issue_rd] = 1'b1;
      if (clr_en_p0)                       clr_mask_p0[clr_rd_p0] = 1'b1;
      busy_p0    = (busy & ~clr_mask_p0) | set_mask_p0;
      busy_p0[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wptr]   <= mem_rd;
         fifo_data[wptr] <= mem_data;
      end
   end

   // ---- stage p0 -> port: FIFO control, scoreboard, write port ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         busy      <= '0;
         RegWrite  <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         busy      <= busy_p0;
         RegWrite  <= wr_en_p0;
         WriteAddr <= wr_addr_p0;
         WriteData <= wr_data_p0;
      end
   end

endmodule
